// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive frame controller.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_HUNT,
    ST_LEN,
    ST_PAYLOAD,
    ST_CHECK,
    ST_HOLD
  } state_t;

  localparam logic [1:0] ERR_NONE = 2'd0;
  localparam logic [1:0] ERR_CHK  = 2'd1;
  localparam logic [1:0] ERR_LEN  = 2'd2;
  localparam logic [1:0] ERR_TMO  = 2'd3;

  localparam logic [7:0] DEFAULT_SOF = 8'hA5;

  // 115200 baud from a 50 MHz clock; timeout is 20 bit times.
  localparam int unsigned CLKS_PER_BIT = 434;
  localparam int unsigned TIMEOUT_CLKS = 20 * CLKS_PER_BIT;

endpackage

// File: rtl/uart_frame_buf.sv
// Payload buffer: simple dual-port RAM, synchronous write, registered read.
module uart_frame_buf #(
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned ADDR_W = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [7:0]        wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [7:0]        rd_data
);

  logic [7:0] mem [DEPTH];

  // Storage itself is never reset; only the read register is.
  always_ff @(posedge clk) begin
    if (we) mem[wr_addr] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (reset) rd_data <= 8'h00;
    else       rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/uart_rx_frame_ctrl.sv
// Sequences UART bytes into SOF/LEN/PAYLOAD/CHK frames, with timeout and overrun tracking.
//   state   | meaning
//   HUNT    | waiting for SOF byte
//   LEN     | expecting length byte
//   PAYLOAD | storing payload bytes
//   CHECK   | expecting checksum byte
//   HOLD    | checked frame held for consumer
module uart_rx_frame_ctrl
  import uart_pkg::*;
#(
  parameter logic [7:0]  SOF_BYTE     = DEFAULT_SOF,
  parameter int unsigned MAX_LEN      = 16,
  parameter int unsigned TIMEOUT_CLKS = uart_pkg::TIMEOUT_CLKS,
  parameter int unsigned LEN_W        = $clog2(MAX_LEN + 1),
  parameter int unsigned ADDR_W       = $clog2(MAX_LEN)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [7:0]        rx_byte,
  input  logic              rx_byte_valid,
  output logic              frame_valid,
  output logic [LEN_W-1:0]  frame_len,
  input  logic              frame_ack,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [7:0]        rd_data,
  output logic              err_pulse,
  output logic [1:0]        err_code,
  output logic [7:0]        overrun_cnt
);

  localparam int unsigned TMR_W     = $clog2(TIMEOUT_CLKS);
  localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(TIMEOUT_CLKS - 1);
  localparam logic [7:0] MAX_LEN_B  = 8'(MAX_LEN);

  state_t            state_q, state_d;
  logic [LEN_W-1:0]  len_q;
  logic [ADDR_W-1:0] idx_q;
  logic [7:0]        sum_q;
  logic [TMR_W-1:0]  tmr_q;
  logic              tmo;
  logic              err_fire;
  logic [1:0]        err_val;
  logic              buf_we;

  // Timer only expires while a frame is in flight; a same-cycle byte wins.
  assign tmo = (state_q inside {ST_LEN, ST_PAYLOAD, ST_CHECK}) &&
               (tmr_q == '0) && !rx_byte_valid;

  always_comb begin
    state_d  = state_q;
    err_fire = 1'b0;
    err_val  = ERR_NONE;
    buf_we   = 1'b0;
    case (state_q)
      ST_HUNT: begin
        if (rx_byte_valid && rx_byte == SOF_BYTE) state_d = ST_LEN;
      end
      ST_LEN: begin
        if (rx_byte_valid) begin
          if (rx_byte == 8'h00 || rx_byte > MAX_LEN_B) begin
            err_fire = 1'b1;
            err_val  = ERR_LEN;
            state_d  = ST_HUNT;
          end else begin
            state_d = ST_PAYLOAD;
          end
        end else if (tmo) begin
          err_fire = 1'b1;
          err_val  = ERR_TMO;
          state_d  = ST_HUNT;
        end
      end
      ST_PAYLOAD: begin
        if (rx_byte_valid) begin
          buf_we = 1'b1;
          if (LEN_W'(idx_q) == len_q - LEN_W'(1)) state_d = ST_CHECK;
        end else if (tmo) begin
          err_fire = 1'b1;
          err_val  = ERR_TMO;
          state_d  = ST_HUNT;
        end
      end
      ST_CHECK: begin
        if (rx_byte_valid) begin
          if (rx_byte == sum_q) begin
            state_d = ST_HOLD;
          end else begin
            err_fire = 1'b1;
            err_val  = ERR_CHK;
            state_d  = ST_HUNT;
          end
        end else if (tmo) begin
          err_fire = 1'b1;
          err_val  = ERR_TMO;
          state_d  = ST_HUNT;
        end
      end
      ST_HOLD: begin
        if (frame_ack) state_d = ST_HUNT;
      end
      default: state_d = ST_HUNT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_HUNT;
    else       state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      len_q       <= '0;
      idx_q       <= '0;
      sum_q       <= 8'h00;
      tmr_q       <= TMR_LOAD;
      frame_len   <= '0;
      err_pulse   <= 1'b0;
      err_code    <= ERR_NONE;
      overrun_cnt <= 8'h00;
    end else begin
      err_pulse <= err_fire;
      if (err_fire) err_code <= err_val;

      if (rx_byte_valid)
        tmr_q <= TMR_LOAD;
      else if ((state_q inside {ST_LEN, ST_PAYLOAD, ST_CHECK}) && tmr_q != '0)
        tmr_q <= tmr_q - TMR_W'(1);

      if (state_q == ST_LEN && state_d == ST_PAYLOAD) begin
        len_q <= rx_byte[LEN_W-1:0];
        idx_q <= '0;
        sum_q <= rx_byte;
      end else if (buf_we) begin
        idx_q <= idx_q + ADDR_W'(1);
        sum_q <= sum_q + rx_byte;
      end

      if (state_q == ST_CHECK && state_d == ST_HOLD) frame_len <= len_q;

      if (state_q == ST_HOLD && rx_byte_valid && overrun_cnt != 8'hFF)
        overrun_cnt <= overrun_cnt + 8'h01;
    end
  end

  assign frame_valid = (state_q == ST_HOLD);

  uart_frame_buf #(
    .DEPTH  (MAX_LEN),
    .ADDR_W (ADDR_W)
  ) u_buf (
    .clk     (clk),
    .reset   (reset),
    .we      (buf_we),
    .wr_addr (idx_q),
    .wr_data (rx_byte),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );

endmodule

// File: tb/tb_uart_rx_frame_ctrl.sv
// Directed bench for uart_rx_frame_ctrl; checksum byte covers LEN plus payload.
module tb_uart_rx_frame_ctrl;

  localparam int TC = 8680;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] rx_byte = 8'h00;
  logic       rx_byte_valid = 1'b0;
  logic       frame_ack = 1'b0;
  logic [3:0] rd_addr = 4'd0;
  logic       frame_valid;
  logic [4:0] frame_len;
  logic [7:0] rd_data;
  logic       err_pulse;
  logic [1:0] err_code;
  logic [7:0] overrun_cnt;

  int n_vec  = 0;
  int n_miss = 0;
  int n_errp = 0;
  int p0;

  uart_rx_frame_ctrl dut (
    .clk           (clk),
    .reset         (reset),
    .rx_byte       (rx_byte),
    .rx_byte_valid (rx_byte_valid),
    .frame_valid   (frame_valid),
    .frame_len     (frame_len),
    .frame_ack     (frame_ack),
    .rd_addr       (rd_addr),
    .rd_data       (rd_data),
    .err_pulse     (err_pulse),
    .err_code      (err_code),
    .overrun_cnt   (overrun_cnt)
  );

  always #10 clk = ~clk;

  always @(posedge clk) begin
    #1;
    if (err_pulse) n_errp++;
  end

  task automatic chk(input string tag, input int unsigned obs, input int unsigned exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [7:0] b);
    rx_byte       = b;
    rx_byte_valid = 1'b1;
    @(negedge clk);
    rx_byte_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic ack();
    frame_ack = 1'b1;
    @(negedge clk);
    frame_ack = 1'b0;
  endtask

  task automatic rd(input logic [3:0] a, input logic [7:0] exp, input string tag);
    rd_addr = a;
    @(negedge clk);
    chk(tag, rd_data, exp);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    idle(3);
    reset = 1'b0;
    chk("rst_valid", frame_valid, 0);
    chk("rst_len",   frame_len,   0);
    chk("rst_errp",  err_pulse,   0);
    chk("rst_errc",  err_code,    0);
    chk("rst_ovr",   overrun_cnt, 0);
    chk("rst_rd",    rd_data,     0);

    // good frame, then ack coincident with a byte (counted as overrun)
    send(8'hA5); send(8'h03); send(8'h11); send(8'h22); send(8'h33); send(8'h69);
    chk("good_valid", frame_valid, 1);
    chk("good_len",   frame_len,   3);
    rd(4'd0, 8'h11, "good_rd0");
    rd(4'd1, 8'h22, "good_rd1");
    rd(4'd2, 8'h33, "good_rd2");
    chk("good_valid_held", frame_valid, 1);
    frame_ack = 1'b1; rx_byte = 8'h5A; rx_byte_valid = 1'b1;
    @(negedge clk);
    frame_ack = 1'b0; rx_byte_valid = 1'b0;
    chk("ack_valid", frame_valid, 0);
    chk("ack_ovr",   overrun_cnt, 1);
    chk("good_noerr", n_errp, 0);

    // bad checksum then a good frame
    p0 = n_errp;
    send(8'hA5); send(8'h03); send(8'h11); send(8'h22); send(8'h33); send(8'h68);
    chk("chk_errp",  err_pulse, 1);
    chk("chk_errc",  err_code,  1);
    chk("chk_valid", frame_valid, 0);
    idle(2);
    chk("chk_pulses", n_errp - p0, 1);
    send(8'hA5); send(8'h03); send(8'h44); send(8'h55); send(8'h66); send(8'h02);
    chk("chk2_valid", frame_valid, 1);
    chk("chk2_len",   frame_len,   3);
    rd(4'd2, 8'h66, "chk2_rd2");
    ack();
    chk("chk2_ack", frame_valid, 0);

    // bad lengths; SOF as length byte is not re-used as a start
    p0 = n_errp;
    send(8'hA5); send(8'h00);
    chk("len0_errp", err_pulse, 1);
    chk("len0_errc", err_code,  2);
    send(8'hA5); send(8'h11);
    chk("len17_errp", err_pulse, 1);
    chk("len17_errc", err_code,  2);
    send(8'hA5); send(8'hA5); send(8'h01); send(8'h7E); send(8'h7F);
    chk("sof_noreex_valid", frame_valid, 0);
    chk("len_pulses", n_errp - p0, 3);
    send(8'hA5); send(8'h01); send(8'h7E); send(8'h7F);
    chk("len_next_valid", frame_valid, 1);
    chk("len_next_len",   frame_len,   1);
    rd(4'd0, 8'h7E, "len_next_rd0");
    ack();

    // garbage before SOF
    send(8'h00); send(8'hFF); send(8'h5A);
    send(8'hA5); send(8'h02); send(8'h01); send(8'h02); send(8'h05);
    chk("garb_valid", frame_valid, 1);
    chk("garb_len",   frame_len,   2);
    rd(4'd0, 8'h01, "garb_rd0");
    rd(4'd1, 8'h02, "garb_rd1");
    ack();

    // timeout at expiry
    p0 = n_errp;
    send(8'hA5); send(8'h02); send(8'h11);
    idle(TC - 1);
    chk("tmo_early", err_pulse, 0);
    idle(1);
    chk("tmo_errp", err_pulse, 1);
    chk("tmo_errc", err_code,  3);
    idle(1);
    chk("tmo_pulse_len", err_pulse, 0);
    chk("tmo_pulses", n_errp - p0, 1);

    // byte on the expiry cycle prevents the timeout
    p0 = n_errp;
    send(8'hA5); send(8'h02); send(8'h11);
    idle(TC - 1);
    send(8'h22);
    chk("tmo_save_errp", err_pulse, 0);
    send(8'h35);
    chk("tmo_save_valid", frame_valid, 1);
    chk("tmo_save_len",   frame_len,   2);
    chk("tmo_save_errc",  err_code,    3);
    chk("tmo_save_pulses", n_errp - p0, 0);
    rd(4'd1, 8'h22, "tmo_save_rd1");
    ack();

    // overrun saturation while held (count starts at 1)
    send(8'hA5); send(8'h02); send(8'h10); send(8'h20); send(8'h32);
    chk("ovr_valid", frame_valid, 1);
    for (int i = 0; i < 253; i++) send(8'(i));
    chk("ovr_254", overrun_cnt, 254);
    send(8'hA5);
    chk("ovr_255", overrun_cnt, 255);
    for (int i = 0; i < 46; i++) send(8'(i + 7));
    chk("ovr_sat", overrun_cnt, 255);
    rd(4'd0, 8'h10, "ovr_rd0");
    rd(4'd1, 8'h20, "ovr_rd1");
    chk("ovr_still_valid", frame_valid, 1);
    ack();
    chk("ovr_ack", frame_valid, 0);

    // reset mid-frame
    p0 = n_errp;
    send(8'hA5); send(8'h02); send(8'h01);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("mrst_errp",  err_pulse,   0);
    chk("mrst_valid", frame_valid, 0);
    chk("mrst_len",   frame_len,   0);
    chk("mrst_errc",  err_code,    0);
    chk("mrst_ovr",   overrun_cnt, 0);
    chk("mrst_rd",    rd_data,     0);
    idle(2);
    chk("mrst_pulses", n_errp - p0, 0);
    send(8'hA5); send(8'h02); send(8'h01); send(8'h02); send(8'h05);
    chk("mrst_next_valid", frame_valid, 1);
    chk("mrst_next_len",   frame_len,   2);
    rd(4'd1, 8'h02, "mrst_next_rd1");
    ack();
    chk("mrst_next_ack", frame_valid, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
